// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and defaults for the memory-stage controller.
// State encoding and default timeout live here.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_DATA_W  = 16;

    // Word access: both strobes together, or an odd address, is illegal.
    function automatic logic is_bad(
        input logic rd,
        input logic wr,
        input logic a0
    );
        return (rd & wr) | a0;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_wait_counter.sv
// Clearable up-counter for WAIT cycles.
// tc rises on the cycle whose increment reaches TIMEOUT-1.
module wait_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 2);

    logic [CW-1:0] cnt;

    // Count enabled cycles; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en & (cnt == TC_VAL);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: XM load/store to mem handshake.
// Stalls upstream while a request is outstanding; sticky error on fault.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              XM_memRead,
    input  logic              XM_memWrite,
    input  logic [DATA_W-1:0] XM_aluOut,
    input  logic [DATA_W-1:0] XM_writeData,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] readData,
    output logic              stall,
    output logic              err
);

    state_t state, state_nx;

    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              acc;
    logic              bad;
    logic              issue;
    logic              tc;
    logic              in_wait;

    assign acc     = XM_memRead | XM_memWrite;
    assign bad     = is_bad(XM_memRead, XM_memWrite, XM_aluOut[0]);
    assign in_wait = (state == ST_WAIT);
    assign issue   = rst_n & (state == ST_IDLE) & acc & ~bad;

    wait_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (~in_wait | mem_done),
        .en   (in_wait & ~mem_done),
        .tc   (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Capture the request when it must be held across WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (issue & ~mem_done) begin
            addr_q  <= XM_aluOut;
            wdata_q <= XM_writeData;
            wr_q    <= XM_memWrite;
        end
    end

    // Next state and output muxing; everything quiet during reset.
    always_comb begin
        state_nx  = state;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        readData  = '0;
        stall     = 1'b0;
        err       = 1'b0;
        if (rst_n) begin
            unique case (state)
                ST_IDLE: begin
                    if (acc & bad) begin
                        state_nx = ST_ERR;
                    end else if (acc) begin
                        mem_en    = 1'b1;
                        mem_wr    = XM_memWrite;
                        mem_addr  = XM_aluOut;
                        mem_wdata = XM_writeData;
                        if (mem_done) begin
                            if (!XM_memWrite) readData = mem_rdata;
                        end else begin
                            stall    = 1'b1;
                            state_nx = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    mem_wr    = wr_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                    if (mem_done) begin
                        if (!wr_q) readData = mem_rdata;
                        state_nx = ST_IDLE;
                    end else begin
                        stall = 1'b1;
                        if (tc) state_nx = ST_ERR;
                    end
                end
                ST_ERR: begin
                    err = 1'b1;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

endmodule
